// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Covers the FSM state encoding, the port-select values and the tie-break helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_END
  } state_e;

  localparam int   ACCESS_CYCLES_DEF = 2;
  localparam logic PORT_A            = 1'b0;
  localparam logic PORT_B            = 1'b1;

  // A lone requester always wins; on a tie the port that was not granted last wins.
  function automatic logic pick_port(input logic a_req, input logic b_req, input logic last_grant);
    if (a_req && !b_req) return PORT_A;
    if (b_req && !a_req) return PORT_B;
    return (last_grant == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles the two requester ports and the SRAM-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_arbiter_if;

  logic        a_req;
  logic [20:0] a_addr;
  logic        a_we;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic [7:0]  a_rdata;

  logic        b_req;
  logic [20:0] b_addr;
  logic        b_we;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;

  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        sram_we_n;

  modport master (
    output a_req, a_addr, a_we, a_wdata,
    output b_req, b_addr, b_we, b_wdata,
    output sram_din,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  sram_addr, sram_dout, sram_doe, sram_we_n
  );

  modport slave (
    input  a_req, a_addr, a_we, a_wdata,
    input  b_req, b_addr, b_we, b_wdata,
    input  sram_din,
    output a_ack, a_rdata, b_ack, b_rdata,
    output sram_addr, sram_dout, sram_doe, sram_we_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> END, one access at a time.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic          sysclk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic [20:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [7:0]  a_rdata_q;
  logic [7:0]  b_rdata_q;

  logic start;
  logic last_access;

  assign start       = (state_q == ST_IDLE) && (bus.a_req || bus.b_req);
  assign last_access = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= PORT_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          grant_d = pick_port(bus.a_req, bus.b_req, grant_q);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (last_access) begin
          cnt_d   = '0;
          state_d = ST_END;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request fields are latched at grant so the requester may drop req mid-access.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (start) begin
        if (grant_d == PORT_A) begin
          addr_q  <= bus.a_addr;
          we_q    <= bus.a_we;
          wdata_q <= bus.a_wdata;
        end else begin
          addr_q  <= bus.b_addr;
          we_q    <= bus.b_we;
          wdata_q <= bus.b_wdata;
        end
      end
      if (last_access && !we_q) begin
        if (grant_q == PORT_A) a_rdata_q <= bus.sram_din;
        else                   b_rdata_q <= bus.sram_din;
      end
    end
  end

  always_comb begin
    bus.sram_addr = addr_q;
    bus.sram_dout = wdata_q;
    bus.sram_doe  = we_q && (state_q != ST_IDLE);
    bus.sram_we_n = !(we_q && (state_q == ST_ACCESS));
    bus.a_ack     = (state_q == ST_END) && (grant_q == PORT_A);
    bus.b_ack     = (state_q == ST_END) && (grant_q == PORT_B);
    bus.a_rdata   = a_rdata_q;
    bus.b_rdata   = b_rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter at ACCESS_CYCLES 2, 1 and 7.
// Expected latencies and strobe widths are hand-derived from the access sequence.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  sram_arbiter_if bus ();
  sram_arbiter_if if1 ();
  sram_arbiter_if if7 ();

  sram_arbiter #(.ACCESS_CYCLES(2)) dut  (.sysclk(sysclk), .rst_n(rst_n), .bus(bus));
  sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (.sysclk(sysclk), .rst_n(rst_n), .bus(if1));
  sram_arbiter #(.ACCESS_CYCLES(7)) dut7 (.sysclk(sysclk), .rst_n(rst_n), .bus(if7));

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic [20:0] addr,
                               input logic we, input logic [7:0] wdata);
    if (port == PORT_A) begin
      bus.a_req = req; bus.a_addr = addr; bus.a_we = we; bus.a_wdata = wdata;
    end else begin
      bus.b_req = req; bus.b_addr = addr; bus.b_we = we; bus.b_wdata = wdata;
    end
  endtask

  // One request on the main DUT; lat counts negedges from issue to ack (-1 on timeout).
  task automatic doTransaction(input logic port, input logic [20:0] addr, input logic we,
                               input logic [7:0] wdata, input logic [7:0] din, input bit dropEarly,
                               output int lat, output int weLow, output int doeCnt,
                               output int ownAcks, output int otherAcks,
                               output logic [20:0] setupAddr, output logic [7:0] setupDout);
    bit   done;
    logic ownAck, otherAck;
    applyStimulus(port, 1'b1, addr, we, wdata);
    bus.sram_din = din;
    lat = 0; weLow = 0; doeCnt = 0; ownAcks = 0; otherAcks = 0; done = 0;
    setupAddr = '0; setupDout = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge sysclk);
      lat++;
      ownAck   = (port == PORT_A) ? bus.a_ack : bus.b_ack;
      otherAck = (port == PORT_A) ? bus.b_ack : bus.a_ack;
      if (lat == 1) begin
        setupAddr = bus.sram_addr;
        setupDout = bus.sram_dout;
      end
      if (!bus.sram_we_n) weLow++;
      if (bus.sram_doe) doeCnt++;
      if (otherAck) otherAcks++;
      if (ownAck) begin
        ownAcks++;
        done = 1;
        applyStimulus(port, 1'b0, addr, we, wdata);
      end
      if (dropEarly && lat == 2) applyStimulus(port, 1'b0, addr, we, wdata);
    end
    if (!done) lat = -1;
    repeat (6) begin
      @(negedge sysclk);
      ownAck   = (port == PORT_A) ? bus.a_ack : bus.b_ack;
      otherAck = (port == PORT_A) ? bus.b_ack : bus.a_ack;
      if (ownAck) ownAcks++;
      if (otherAck) otherAcks++;
      if (!bus.sram_we_n) weLow++;
    end
  endtask

  initial begin
    int          lat, weLow, doeCnt, own, other;
    logic [20:0] sa;
    logic [7:0]  sd;
    int          ackT[4];
    int          ackP[4];
    int          nAck, bothAck, aLat, bLat, l1, l7, w1, w7;

    applyStimulus(PORT_A, 1'b0, '0, 1'b0, '0);
    applyStimulus(PORT_B, 1'b0, '0, 1'b0, '0);
    bus.sram_din = '0;
    if1.a_req = 0; if1.a_addr = '0; if1.a_we = 0; if1.a_wdata = '0;
    if1.b_req = 0; if1.b_addr = '0; if1.b_we = 0; if1.b_wdata = '0; if1.sram_din = '0;
    if7.a_req = 0; if7.a_addr = '0; if7.a_we = 0; if7.a_wdata = '0;
    if7.b_req = 0; if7.b_addr = '0; if7.b_we = 0; if7.b_wdata = '0; if7.sram_din = '0;

    repeat (2) @(negedge sysclk);
    checkOutput("reset_we_n",    32'(bus.sram_we_n), 32'd1);
    checkOutput("reset_doe",     32'(bus.sram_doe),  32'd0);
    checkOutput("reset_addr",    32'(bus.sram_addr), 32'd0);
    checkOutput("reset_dout",    32'(bus.sram_dout), 32'd0);
    checkOutput("reset_a_ack",   32'(bus.a_ack),     32'd0);
    checkOutput("reset_b_ack",   32'(bus.b_ack),     32'd0);
    checkOutput("reset_a_rdata", 32'(bus.a_rdata),   32'd0);
    checkOutput("reset_b_rdata", 32'(bus.b_rdata),   32'd0);

    rst_n = 1'b1;
    @(negedge sysclk);
    checkOutput("idle_doe", 32'(bus.sram_doe), 32'd0);

    // Port A read of 0x1ABCD returning 0x5A.
    doTransaction(PORT_A, 21'h1ABCD, 1'b0, 8'h00, 8'h5A, 1'b0, lat, weLow, doeCnt, own, other, sa, sd);
    checkOutput("rdA_latency",    32'(lat),           32'd4);
    checkOutput("rdA_setup_addr", 32'(sa),            32'h1ABCD);
    checkOutput("rdA_we_low",     32'(weLow),         32'd0);
    checkOutput("rdA_doe_cycles", 32'(doeCnt),        32'd0);
    checkOutput("rdA_acks",       32'(own),           32'd1);
    checkOutput("rdA_other_acks", 32'(other),         32'd0);
    checkOutput("rdA_rdata",      32'(bus.a_rdata),   32'h5A);
    checkOutput("rdA_idle_addr",  32'(bus.sram_addr), 32'h1ABCD);
    checkOutput("rdA_idle_doe",   32'(bus.sram_doe),  32'd0);

    // Port B write 0xC3 to 0x00010; din is junk and must not reach b_rdata.
    doTransaction(PORT_B, 21'h00010, 1'b1, 8'hC3, 8'hFF, 1'b0, lat, weLow, doeCnt, own, other, sa, sd);
    checkOutput("wrB_latency",    32'(lat),           32'd4);
    checkOutput("wrB_setup_addr", 32'(sa),            32'h00010);
    checkOutput("wrB_setup_dout", 32'(sd),            32'hC3);
    checkOutput("wrB_we_low",     32'(weLow),         32'd2);
    checkOutput("wrB_doe_cycles", 32'(doeCnt),        32'd4);
    checkOutput("wrB_acks",       32'(own),           32'd1);
    checkOutput("wrB_other_acks", 32'(other),         32'd0);
    checkOutput("wrB_b_rdata",    32'(bus.b_rdata),   32'h00);
    checkOutput("wrB_a_rdata",    32'(bus.a_rdata),   32'h5A);
    checkOutput("wrB_idle_doe",   32'(bus.sram_doe),  32'd0);
    checkOutput("wrB_idle_dout",  32'(bus.sram_dout), 32'hC3);

    // Port B read whose request is withdrawn during ACCESS.
    doTransaction(PORT_B, 21'h00020, 1'b0, 8'h00, 8'h77, 1'b1, lat, weLow, doeCnt, own, other, sa, sd);
    checkOutput("dropB_latency",  32'(lat),          32'd4);
    checkOutput("dropB_acks",     32'(own),          32'd1);
    checkOutput("dropB_rdata",    32'(bus.b_rdata),  32'h77);
    checkOutput("dropB_idle_doe", 32'(bus.sram_doe), 32'd0);

    // Both ports held high: last grant was B, so A, B, A, B every 5 cycles.
    bus.sram_din = 8'h3C;
    applyStimulus(PORT_A, 1'b1, 21'h00100, 1'b0, 8'h00);
    applyStimulus(PORT_B, 1'b1, 21'h00200, 1'b0, 8'h00);
    nAck = 0; bothAck = 0;
    for (int k = 0; k < 4; k++) begin ackT[k] = -1; ackP[k] = -1; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge sysclk);
      if (bus.a_ack && bus.b_ack) bothAck++;
      if ((bus.a_ack || bus.b_ack) && nAck < 4) begin
        ackT[nAck] = c;
        ackP[nAck] = bus.b_ack ? 1 : 0;
        nAck++;
      end
    end
    applyStimulus(PORT_A, 1'b0, 21'h00100, 1'b0, 8'h00);
    applyStimulus(PORT_B, 1'b0, 21'h00200, 1'b0, 8'h00);
    checkOutput("rr_both_acks", 32'(bothAck), 32'd0);
    checkOutput("rr_t0", 32'(ackT[0]), 32'd4);
    checkOutput("rr_t1", 32'(ackT[1]), 32'd9);
    checkOutput("rr_t2", 32'(ackT[2]), 32'd14);
    checkOutput("rr_t3", 32'(ackT[3]), 32'd19);
    checkOutput("rr_p0", 32'(ackP[0]), 32'd0);
    checkOutput("rr_p1", 32'(ackP[1]), 32'd1);
    checkOutput("rr_p2", 32'(ackP[2]), 32'd0);
    checkOutput("rr_p3", 32'(ackP[3]), 32'd1);
    repeat (3) @(negedge sysclk);
    checkOutput("rr_a_rdata", 32'(bus.a_rdata), 32'h3C);
    checkOutput("rr_b_rdata", 32'(bus.b_rdata), 32'h3C);

    // Reset during a write ACCESS, with A queued behind it.
    applyStimulus(PORT_B, 1'b1, 21'h003FF, 1'b1, 8'h11);
    repeat (2) @(negedge sysclk);
    checkOutput("abort_we_low_before", 32'(bus.sram_we_n), 32'd0);
    applyStimulus(PORT_A, 1'b1, 21'h00555, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_we_n",  32'(bus.sram_we_n), 32'd1);
    checkOutput("abort_doe",   32'(bus.sram_doe),  32'd0);
    checkOutput("abort_addr",  32'(bus.sram_addr), 32'd0);
    checkOutput("abort_b_ack", 32'(bus.b_ack),     32'd0);
    @(negedge sysclk);
    checkOutput("abort_b_ack_held", 32'(bus.b_ack), 32'd0);
    rst_n = 1'b1;
    aLat = -1; bLat = -1;
    for (int c = 1; c <= 30 && (aLat < 0 || bLat < 0); c++) begin
      @(negedge sysclk);
      if (bus.a_ack && aLat < 0) begin aLat = c; bus.a_req = 1'b0; end
      if (bus.b_ack && bLat < 0) begin bLat = c; bus.b_req = 1'b0; end
    end
    checkOutput("post_reset_a_first", 32'(aLat), 32'd4);
    checkOutput("post_reset_b_next",  32'(bLat), 32'd9);

    // Same write on the ACCESS_CYCLES=1 and =7 instances.
    if1.b_addr = 21'h00042; if1.b_we = 1'b1; if1.b_wdata = 8'h99; if1.b_req = 1'b1;
    if7.b_addr = 21'h00042; if7.b_we = 1'b1; if7.b_wdata = 8'h99; if7.b_req = 1'b1;
    l1 = -1; l7 = -1; w1 = 0; w7 = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge sysclk);
      if (!if1.sram_we_n) w1++;
      if (!if7.sram_we_n) w7++;
      if (if1.b_ack && l1 < 0) begin l1 = c; if1.b_req = 1'b0; end
      if (if7.b_ack && l7 < 0) begin l7 = c; if7.b_req = 1'b0; end
    end
    checkOutput("ac1_latency", 32'(l1), 32'd3);
    checkOutput("ac7_latency", 32'(l7), 32'd9);
    checkOutput("ac1_we_low",  32'(w1), 32'd1);
    checkOutput("ac7_we_low",  32'(w7), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of sysclk cycles sram_we_n/read strobe is held (legal 1..7).
REQ-002 sysclk  in  1  single system clock (28 MHz nominal); one clock, no other clock domains.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 a_req  in  1  port A (video fetch) request, level, held until a_ack.
REQ-005 a_addr  in  21  port A SRAM address.
REQ-006 a_we  in  1  port A write (1) / read (0).
REQ-007 a_wdata  in  8  port A write data.
REQ-008 a_ack  out  1  port A one-cycle completion pulse.
REQ-009 a_rdata  out  8  port A read data, valid from a_ack cycle, held until next port A read completes.
REQ-010 b_req, b_addr[21], b_we, b_wdata[8], b_ack, b_rdata[8]  port B (CPU/DMA), same semantics as port A.
REQ-011 sram_addr  out  21  SRAM address bus.
REQ-012 sram_dout  out  8  data driven to SRAM.
REQ-013 sram_doe  out  1  data-bus output enable (tri-state handled at top level).
REQ-014 sram_din  in  8  data read from SRAM.
REQ-015 sram_we_n  out  1  SRAM write strobe, active low.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, END; one access in flight at a time.
REQ-017 IDLE: only a_req -> grant A; only b_req -> grant B; both -> grant port not in last_grant register; none -> stay IDLE.
REQ-018 On grant: register address, we, wdata of granted port; update last_grant; go SETUP.
REQ-019 SETUP (1 cycle): sram_addr valid, sram_doe=we, sram_dout=wdata, sram_we_n=1.
REQ-020 ACCESS: exactly ACCESS_CYCLES cycles, counter from 0; sram_we_n=0 iff write; address/data/doe stable.
REQ-021 Read: sram_din captured into granted port's rdata on last ACCESS cycle.
REQ-022 END (1 cycle): sram_we_n=1, address/data/doe still held (hold time); granted port ack=1; next state IDLE.
REQ-023 Access latency: grant edge to ack = ACCESS_CYCLES+2 cycles; back-to-back period ACCESS_CYCLES+3.
REQ-024 Requester deassertion of req mid-access: access completes and ack still pulses; no abort.
REQ-025 req still high in IDLE after ack: treated as new request (requester drops req on the edge it samples ack).
REQ-026 Never assert a_ack and b_ack in the same cycle; sram_we_n never low outside ACCESS.
REQ-027 sram_doe=0 in IDLE; sram_addr and sram_dout hold last values in IDLE.
REQ-028 Request arriving during SETUP/ACCESS/END waits; arbitration only in IDLE.

Reset
REQ-029 rst_n low: state=IDLE, sram_we_n=1, sram_doe=0, sram_addr=0, sram_dout=0, acks=0, rdata=0, counter=0, last_grant=B (A wins first tie).
REQ-030 Reset asserted mid-access: all outputs to reset values immediately; aborted transaction gets no ack.

Structure
REQ-031 Shared package sram_arb_pkg: state enum, ACCESS_CYCLES default, port-select constants PORT_A/PORT_B.
REQ-032 Single flat module; no sub-module (counter and arbitration inline).

Verification
REQ-033 Reset release, a_req read at 0x1ABCD, sram_din=0x5A -> sram_addr=0x1ABCD from SETUP, a_ack 4 cycles after grant, a_rdata=0x5A.
REQ-034 b_req write 0x00010<-0xC3 -> sram_we_n low exactly 2 cycles, sram_doe=1 SETUP..END, sram_dout=0xC3, b_ack once.
REQ-035 a_req and b_req both held high continuously -> grants alternate A,B,A,B; each ack every 5 cycles.
REQ-036 b_req dropped during ACCESS -> b_ack still pulses, no second access; bus returns IDLE with sram_doe=0.
REQ-037 rst_n low during ACCESS of a write -> sram_we_n=1 and sram_doe=0 same cycle, no ack; after release, pending a_req served first.
REQ-038 ACCESS_CYCLES=1 and 7 -> ack latency 3 and 9 cycles; sram_we_n low width 1 and 7.
